// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : shared constants and state encodings for the pipeline control unit.
// Revision      : 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  localparam logic c_stop           = 1'b1;
  localparam logic c_no_stop        = 1'b0;
  localparam logic c_pipeline_flush = 1'b1;
  localparam logic c_no_flush       = 1'b0;

  // Bit k holds stage k (0 = pc ... 5 = wb); wb is never held.
  localparam logic [5:0] c_stall_none = 6'b000000;
  localparam logic [5:0] c_stall_if   = 6'b000011;
  localparam logic [5:0] c_stall_id   = 6'b000111;
  localparam logic [5:0] c_stall_ex   = 6'b001111;
  localparam logic [5:0] c_stall_mem  = 6'b011111;

  typedef logic [1:0] ctrl_state_t;
  localparam ctrl_state_t c_st_run   = 2'd0;
  localparam ctrl_state_t c_st_drain = 2'd1;
  localparam ctrl_state_t c_st_flush = 2'd2;

  localparam logic [1:0] c_mtvec_vectored = 2'b01;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// pipe_ctrl_if : stall/trap request bundle between the core stages and pipe_ctrl.
// Optional macro PIPE_CTRL_WDT_EN adds stall_timeout_o.  Revision : 1.0
// ============================================================================
`default_nettype none

interface pipe_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              stallreq_if_i;
  logic              stallreq_id_i;
  logic              stallreq_ex_i;
  logic              stallreq_mem_i;
  logic              exc_req_i;
  logic              exc_is_irq_i;
  logic [4:0]        exc_cause_i;
  logic              mret_req_i;
  logic [ADDR_W-1:0] mtvec_i;
  logic [ADDR_W-1:0] mepc_i;
  logic [5:0]        stall_o;
  logic              flush_o;
  logic [ADDR_W-1:0] new_pc_o;
  logic              trap_taken_o;
  logic [5:0]        trap_cause_o;
  logic              busy_o;
`ifdef PIPE_CTRL_WDT_EN
  logic              stall_timeout_o;
`endif

  modport master (
    input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    input  exc_req_i, exc_is_irq_i, exc_cause_i, mret_req_i, mtvec_i, mepc_i,
`ifdef PIPE_CTRL_WDT_EN
    output stall_timeout_o,
`endif
    output stall_o, flush_o, new_pc_o, trap_taken_o, trap_cause_o, busy_o
  );

  modport slave (
    output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    output exc_req_i, exc_is_irq_i, exc_cause_i, mret_req_i, mtvec_i, mepc_i,
`ifdef PIPE_CTRL_WDT_EN
    input  stall_timeout_o,
`endif
    input  stall_o, flush_o, new_pc_o, trap_taken_o, trap_cause_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl_trap_vec_gen.sv
// ============================================================================
// trap_vec_gen : combinational mtvec/cause to trap target address.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module trap_vec_gen
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] mtvec,
  input  logic              is_irq,
  input  logic [4:0]        cause,
  output logic [ADDR_W-1:0] target
);

  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_offset;

  assign w_base   = {mtvec[ADDR_W-1:2], 2'b00};
  assign w_offset = {{(ADDR_W-7){1'b0}}, cause, 2'b00};

  assign target = (mtvec[1:0] == c_mtvec_vectored && is_irq) ? (w_base + w_offset) : w_base;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : stall merging and trap/mret flush sequencing for the 6-stage core.
// Optional macro PIPE_CTRL_WDT_EN adds a sticky stall watchdog.  Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int ADDR_W       = 32,
  parameter int WDT_LIMIT    = 1023
) (
  input  logic       clk_i,
  input  logic       n_rst_i,
  pipe_ctrl_if.master bus
);

  localparam int CNT_W = 4;

  ctrl_state_t       r_state;
  ctrl_state_t       w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [5:0]        w_stall_enc;
  logic [5:0]        w_stall;
  logic              w_accept;
  logic              w_enter_flush;
  logic [ADDR_W-1:0] w_trap_target;
  logic [ADDR_W-1:0] r_new_pc;
  logic [5:0]        r_trap_cause;
  logic              r_is_trap;

  trap_vec_gen #(.ADDR_W(ADDR_W)) u_trap_vec_gen (
    .mtvec  (bus.mtvec_i),
    .is_irq (bus.exc_is_irq_i),
    .cause  (bus.exc_cause_i),
    .target (w_trap_target)
  );

  always_comb begin
    w_stall_enc = c_stall_none;
    if (bus.stallreq_mem_i)     w_stall_enc = c_stall_mem;
    else if (bus.stallreq_ex_i) w_stall_enc = c_stall_ex;
    else if (bus.stallreq_id_i) w_stall_enc = c_stall_id;
    else if (bus.stallreq_if_i) w_stall_enc = c_stall_if;
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) r_state <= c_st_run;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_run: begin
        if (bus.exc_req_i)       w_next_state = bus.stallreq_mem_i ? c_st_drain : c_st_flush;
        else if (bus.mret_req_i) w_next_state = c_st_flush;
      end
      c_st_drain: if (!bus.stallreq_mem_i) w_next_state = c_st_flush;
      c_st_flush: if (r_cnt == '0)         w_next_state = c_st_run;
      default:                             w_next_state = c_st_run;
    endcase
  end

  assign w_accept      = (r_state == c_st_run) && (bus.exc_req_i || bus.mret_req_i);
  assign w_enter_flush = (r_state != c_st_flush) && (w_next_state == c_st_flush);

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i)                  r_cnt <= '0;
    else if (w_enter_flush)        r_cnt <= CNT_W'(FLUSH_CYCLES - 1);
    else if (r_state == c_st_flush && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  // Trap wins over a simultaneous mret; the target is frozen at acceptance so
  // CSR changes during drain cannot move the redirect.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_new_pc     <= '0;
      r_trap_cause <= '0;
      r_is_trap    <= 1'b0;
    end else if (w_accept) begin
      r_new_pc     <= bus.exc_req_i ? w_trap_target : bus.mepc_i;
      r_trap_cause <= {bus.exc_is_irq_i, bus.exc_cause_i};
      r_is_trap    <= bus.exc_req_i;
    end
  end

  always_comb begin
    w_stall          = c_stall_none;
    bus.flush_o      = c_no_flush;
    bus.busy_o       = 1'b0;
    bus.trap_taken_o = 1'b0;
    case (r_state)
      c_st_run:   w_stall = w_stall_enc;
      c_st_drain: begin
        w_stall    = c_stall_mem;
        bus.busy_o = 1'b1;
      end
      c_st_flush: begin
        bus.flush_o      = c_pipeline_flush;
        bus.busy_o       = 1'b1;
        bus.trap_taken_o = r_is_trap && (r_cnt == CNT_W'(FLUSH_CYCLES - 1));
      end
      default: ;
    endcase
  end

  assign bus.stall_o      = w_stall;
  assign bus.new_pc_o     = r_new_pc;
  assign bus.trap_cause_o = r_trap_cause;

`ifdef PIPE_CTRL_WDT_EN
  localparam int WDT_W = ($clog2(WDT_LIMIT + 1) > 10) ? $clog2(WDT_LIMIT + 1) : 10;

  logic [WDT_W-1:0] r_wdt_cnt;
  logic             r_timeout;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_wdt_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_stall == c_stall_none)                r_wdt_cnt <= '0;
      else if (r_wdt_cnt != WDT_W'(WDT_LIMIT))    r_wdt_cnt <= r_wdt_cnt + 1'b1;
      if (r_wdt_cnt == WDT_W'(WDT_LIMIT))         r_timeout <= 1'b1;
    end
  end

  assign bus.stall_timeout_o = r_timeout;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : directed checks of stall encoding and trap/mret sequencing.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.ADDR_W(32)) bus1 ();
  pipe_ctrl_if #(.ADDR_W(32)) bus3 ();

  pipe_ctrl #(.FLUSH_CYCLES(1), .ADDR_W(32)) u_dut1 (
    .clk_i   (clk),
    .n_rst_i (rst_n),
    .bus     (bus1)
  );

  pipe_ctrl #(.FLUSH_CYCLES(3), .ADDR_W(32)) u_dut3 (
    .clk_i   (clk),
    .n_rst_i (rst_n),
    .bus     (bus3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus1.stallreq_if_i = 0; bus1.stallreq_id_i = 0; bus1.stallreq_ex_i = 0;
    bus1.stallreq_mem_i = 0; bus1.exc_req_i = 0; bus1.exc_is_irq_i = 0;
    bus1.exc_cause_i = 0; bus1.mret_req_i = 0; bus1.mtvec_i = 0; bus1.mepc_i = 0;
    bus3.stallreq_if_i = 0; bus3.stallreq_id_i = 0; bus3.stallreq_ex_i = 0;
    bus3.stallreq_mem_i = 0; bus3.exc_req_i = 0; bus3.exc_is_irq_i = 0;
    bus3.exc_cause_i = 0; bus3.mret_req_i = 0; bus3.mtvec_i = 0; bus3.mepc_i = 0;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out1(input string tag, input logic [5:0] stall, input logic flush,
                            input logic [31:0] pc, input logic taken, input logic [5:0] cause,
                            input logic busy);
    check({tag, ".stall"}, 32'(bus1.stall_o), 32'(stall));
    check({tag, ".flush"}, 32'(bus1.flush_o), 32'(flush));
    check({tag, ".new_pc"}, bus1.new_pc_o, pc);
    check({tag, ".taken"}, 32'(bus1.trap_taken_o), 32'(taken));
    check({tag, ".cause"}, 32'(bus1.trap_cause_o), 32'(cause));
    check({tag, ".busy"}, 32'(bus1.busy_o), 32'(busy));
  endtask

  initial begin
    idle();
    #12;
    check_out1("reset", 6'h00, 0, 32'h0, 0, 6'h00, 0);
    rst_n = 1'b1;
    step();

    // Stall encoding, zero latency
    bus1.stallreq_id_i = 1; bus1.stallreq_ex_i = 1; #1;
    check("stall_id_ex", 32'(bus1.stall_o), 32'h0F);
    bus1.stallreq_id_i = 0; bus1.stallreq_ex_i = 0; #1;
    check("stall_none", 32'(bus1.stall_o), 32'h00);
    bus1.stallreq_if_i = 1; #1;
    check("stall_if", 32'(bus1.stall_o), 32'h03);
    bus1.stallreq_id_i = 1; #1;
    check("stall_if_id", 32'(bus1.stall_o), 32'h07);
    bus1.stallreq_mem_i = 1; #1;
    check("stall_mem_all", 32'(bus1.stall_o), 32'h1F);
    idle(); #1;
    check("stall_clear", 32'(bus1.stall_o), 32'h00);

    // Direct trap, mem idle, FLUSH_CYCLES=1
    bus1.mtvec_i = 32'h0000_0100; bus1.exc_cause_i = 5'd2; bus1.exc_req_i = 1;
    step();
    bus1.exc_req_i = 0; #1;
    check_out1("trap1", 6'h00, 1, 32'h100, 1, 6'h02, 1);
    step(); #1;
    check_out1("trap1_done", 6'h00, 0, 32'h100, 0, 6'h02, 0);

    // Vectored interrupt
    bus1.mtvec_i = 32'h0000_0101; bus1.exc_is_irq_i = 1; bus1.exc_cause_i = 5'd7;
    bus1.exc_req_i = 1;
    step();
    bus1.exc_req_i = 0; bus1.exc_is_irq_i = 0; #1;
    check_out1("vec_irq", 6'h00, 1, 32'h11C, 1, 6'h27, 1);
    step(); #1;
    check("vec_irq_done.flush", 32'(bus1.flush_o), 0);

    // Trap while LSU busy for 3 cycles; mret during drain is ignored
    bus1.mtvec_i = 32'h0000_0100; bus1.exc_cause_i = 5'd3; bus1.stallreq_mem_i = 1;
    bus1.exc_req_i = 1;
    step();
    bus1.exc_req_i = 0; bus1.mret_req_i = 1; bus1.mepc_i = 32'h200;
    bus1.mtvec_i = 32'h0000_0300; #1;
    check_out1("drain1", 6'h1F, 0, 32'h100, 0, 6'h03, 1);
    step(); #1;
    check_out1("drain2", 6'h1F, 0, 32'h100, 0, 6'h03, 1);
    bus1.stallreq_mem_i = 0; #1;
    check_out1("drain3", 6'h1F, 0, 32'h100, 0, 6'h03, 1);
    step();
    bus1.mret_req_i = 0; #1;
    check_out1("drain_flush", 6'h00, 1, 32'h100, 1, 6'h03, 1);
    step(); #1;
    check_out1("drain_done", 6'h00, 0, 32'h100, 0, 6'h03, 0);

    // exc and mret together: trap wins
    bus1.mtvec_i = 32'h0000_0100; bus1.mepc_i = 32'h200; bus1.exc_cause_i = 5'd1;
    bus1.exc_req_i = 1; bus1.mret_req_i = 1;
    step();
    bus1.exc_req_i = 0; bus1.mret_req_i = 0; #1;
    check_out1("exc_mret", 6'h00, 1, 32'h100, 1, 6'h01, 1);
    step(); #1;

    // mret with FLUSH_CYCLES=3; exc arriving during flush is ignored
    bus3.mepc_i = 32'h200; bus3.mtvec_i = 32'h0000_0400; bus3.mret_req_i = 1;
    step();
    bus3.mret_req_i = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) bus3.exc_req_i = 1;
      #1;
      check($sformatf("mret_flush%0d", i), 32'(bus3.flush_o), 1);
      check($sformatf("mret_pc%0d", i), bus3.new_pc_o, 32'h200);
      check($sformatf("mret_taken%0d", i), 32'(bus3.trap_taken_o), 0);
      check($sformatf("mret_busy%0d", i), 32'(bus3.busy_o), 1);
      step();
    end
    bus3.exc_req_i = 0; #1;
    check("mret_done.flush", 32'(bus3.flush_o), 0);
    check("mret_done.busy", 32'(bus3.busy_o), 0);
    step(); #1;
    check("mret_ignored_exc.flush", 32'(bus3.flush_o), 0);
    check("mret_ignored_exc.pc", bus3.new_pc_o, 32'h200);

    // Reset mid-flush clears everything at once
    bus3.mepc_i = 32'h240; bus3.mret_req_i = 1;
    step();
    bus3.mret_req_i = 0; #1;
    check("mid_flush.flush", 32'(bus3.flush_o), 1);
    rst_n = 1'b0; #1;
    check("rst_mid.flush", 32'(bus3.flush_o), 0);
    check("rst_mid.new_pc", bus3.new_pc_o, 32'h0);
    check("rst_mid.busy", 32'(bus3.busy_o), 0);
    check("rst_mid.cause", 32'(bus3.trap_cause_o), 0);
    check("rst_mid.taken", 32'(bus3.trap_taken_o), 0);
    check("rst_mid.stall", 32'(bus3.stall_o), 0);
    check_out1("rst_mid_dut1", 6'h00, 0, 32'h0, 0, 6'h00, 0);
    step();
    rst_n = 1'b1;
    step(); #1;
    check("post_rst.flush", 32'(bus3.flush_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
